// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared widths, requester id and tag types for the
// ROM arbiter (rom_arbiter, rom_arb_tag_pipe).
package rom_arb_pkg;

    localparam int ROM_AW     = 8;
    localparam int ROM_DW     = 8;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/rom_arb_tag_pipe.sv
// rom_arb_tag_pipe: RD_LAT-deep shift register of read tags.
// Ports: i_clk, i_rst_n (async clear), i_tag in, o_tag (exiting tag).
module rom_arb_tag_pipe
    import rom_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_pipe [RD_LAT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_tag = r_pipe[RD_LAT-1];

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one synchronous ROM between two requesters,
// tagging each issued read and returning data with a per-requester
// valid strobe.
// Ports: sys_clk, rst_n; req0/addr0, req1/addr1 in; gnt0/gnt1 out;
// rdata, rvalid0/rvalid1 out; rom_addr out, rom_q in.
// Build option: ROM_ARB_FIXED_PRIO_EN selects fixed priority (req0
// wins) instead of the default round-robin.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ROM_AW-1:0] addr0,
    input  logic              req1,
    input  logic [ROM_AW-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [ROM_DW-1:0] rdata,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [ROM_DW-1:0] rom_q
);

    logic              w_any;
    logic              w_pick1;
    tag_t              w_tag_in;
    tag_t              w_tag_out;
    logic              r_gnt0;
    logic              r_gnt1;
    logic [ROM_AW-1:0] r_rom_addr;
    logic [ROM_DW-1:0] r_rdata;
    logic              r_rvalid0;
    logic              r_rvalid1;

    assign w_any = req0 | req1;

`ifdef ROM_ARB_FIXED_PRIO_EN
    assign w_pick1 = req1 & ~req0;
`else
    // r_prio1 set means requester 1 wins the next tie
    logic r_prio1;

    assign w_pick1 = req1 & (~req0 | r_prio1);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio1 <= 1'b0;
        end else if (w_any) begin
            r_prio1 <= ~w_pick1;
        end
    end
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            r_gnt0 <= w_any & ~w_pick1;
            r_gnt1 <= w_pick1;
            if (w_any) begin
                r_rom_addr <= w_pick1 ? addr1 : addr0;
            end
        end
    end

    // The tag enters the pipe one edge after the grant, lining its exit
    // up with the cycle in which rom_q carries that read's data.
    assign w_tag_in.valid = r_gnt0 | r_gnt1;
    assign w_tag_in.id    = r_gnt1 ? REQ1 : REQ0;

    rom_arb_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .i_clk   (sys_clk),
        .i_rst_n (rst_n),
        .i_tag   (w_tag_in),
        .o_tag   (w_tag_out)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata   <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_tag_out.valid & (w_tag_out.id == REQ0);
            r_rvalid1 <= w_tag_out.valid & (w_tag_out.id == REQ1);
            if (w_tag_out.valid) begin
                r_rdata <= rom_q;
            end
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign rom_addr = r_rom_addr;
    assign rdata    = r_rdata;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: two arbiters (RD_LAT 1 and 2) share one stimulus
// table; grants are checked per vector, returns via scoreboards.
module tb_rom_arbiter;
  import rom_arb_pkg::*;

`ifdef ROM_ARB_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic [7:0] addr0 = '0;
  logic [7:0] addr1 = '0;

  logic g0_1, g1_1, rv0_1, rv1_1;
  logic [7:0] rd_1, ra_1, rq_1;
  logic g0_2, g1_2, rv0_2, rv1_2;
  logic [7:0] rd_2, ra_2, rq_2, rs_2;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic r0;
    logic [7:0] a0;
    logic r1;
    logic [7:0] a1;
    logic e0;
    logic e1;
  } vec_t;

  typedef struct {
    logic id;
    logic [7:0] data;
    int due;
  } exp_t;

  vec_t tv[$];
  exp_t q1[$];
  exp_t q2[$];

  rom_arbiter #(.RD_LAT(1)) u_dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0),
    .req1(req1), .addr1(addr1),
    .gnt0(g0_1), .gnt1(g1_1),
    .rdata(rd_1),
    .rvalid0(rv0_1), .rvalid1(rv1_1),
    .rom_addr(ra_1), .rom_q(rq_1)
  );

  rom_arbiter #(.RD_LAT(2)) u_dut2 (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0),
    .req1(req1), .addr1(addr1),
    .gnt0(g0_2), .gnt1(g1_2),
    .rdata(rd_2),
    .rvalid0(rv0_2), .rvalid1(rv1_2),
    .rom_addr(ra_2), .rom_q(rq_2)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc++;

  function automatic logic [7:0] romf(
    input logic [7:0] a
  );
    return {a[3:0], a[7:4]} ^ 8'hA5;
  endfunction

  always @(posedge sys_clk) begin
    rq_1 <= romf(ra_1);
    rs_2 <= romf(ra_2);
    rq_2 <= rs_2;
  end

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(
    input logic r0, input logic [7:0] a0,
    input logic r1, input logic [7:0] a1,
    input logic e0, input logic e1
  );
    vec_t v;
    v.r0 = r0; v.a0 = a0;
    v.r1 = r1; v.a1 = a1;
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic mon(
    input int k,
    input logic v0, input logic v1,
    input logic [7:0] d
  );
    exp_t e;
    bit have;
    have = 1'b0;
    chk($sformatf("one_rvalid_l%0d", k), 32'(v0 & v1), 0);
    if (v0 | v1) begin
      if (k == 1 && q1.size() > 0) begin
        e = q1.pop_front(); have = 1'b1;
      end
      if (k == 2 && q2.size() > 0) begin
        e = q2.pop_front(); have = 1'b1;
      end
      if (!have) begin
        chk($sformatf("unexpected_rvalid_l%0d", k), 1, 0);
      end else begin
        chk($sformatf("rv_id_l%0d", k), 32'(v1), 32'(e.id));
        chk($sformatf("rdata_l%0d", k), 32'(d), 32'(e.data));
        chk($sformatf("rv_cycle_l%0d", k), cyc, e.due);
      end
    end
  endtask

  always @(negedge sys_clk) begin
    if (rst_n) begin
      mon(1, rv0_1, rv1_1, rd_1);
      mon(2, rv0_2, rv1_2, rd_2);
    end
  end

  task automatic apply(input vec_t v, input bit sb);
    logic [7:0] a;
    exp_t e;
    req0 = v.r0; addr0 = v.a0;
    req1 = v.r1; addr1 = v.a1;
    @(negedge sys_clk);
    chk("gnt0_l1", 32'(g0_1), 32'(v.e0));
    chk("gnt1_l1", 32'(g1_1), 32'(v.e1));
    chk("gnt0_l2", 32'(g0_2), 32'(v.e0));
    chk("gnt1_l2", 32'(g1_2), 32'(v.e1));
    if (v.e0 | v.e1) begin
      a = v.e1 ? v.a1 : v.a0;
      chk("rom_addr_l1", 32'(ra_1), 32'(a));
      chk("rom_addr_l2", 32'(ra_2), 32'(a));
      if (sb) begin
        e.id = v.e1;
        e.data = romf(a);
        e.due = cyc + 2;
        q1.push_back(e);
        e.due = cyc + 3;
        q2.push_back(e);
      end
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_l1"},
        {8'(g0_1), 8'(g1_1), 8'(rv0_1), 8'(rv1_1), rd_1, ra_1}, 0);
    chk({nm, "_l2"},
        {8'(g0_2), 8'(g1_2), 8'(rv0_2), 8'(rv1_2), rd_2, ra_2}, 0);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      tv.push_back(mk(1, 8'h10, 1, 8'h20,
                      FP ? 1'b1 : 1'(i % 2 == 0),
                      FP ? 1'b0 : 1'(i % 2 == 1)));
    end
    repeat (4) tv.push_back(mk(0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 8'h05, 0, 0, 1, 0));
    repeat (4) tv.push_back(mk(0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 8'hFE, 0, 1));
    tv.push_back(mk(0, 0, 1, 8'hFF, 0, 1));
    tv.push_back(mk(0, 0, 1, 8'h00, 0, 1));
    repeat (5) tv.push_back(mk(0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 8'h77, 0, 0, 1, 0));
    tv.push_back(mk(1, 8'h78, 1, 8'h99, FP, !FP));
    tv.push_back(mk(1, 8'h78, 0, 0, 1, 0));
    repeat (4) tv.push_back(mk(0, 0, 0, 0, 0, 0));

    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_zero("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      chk_zero("idle_after_reset");
    end

    for (int i = 0; i < tv.size(); i++) begin
      apply(tv[i], 1'b1);
    end

    // read issued, then reset one cycle later: it must never return
    apply(mk(1, 8'h33, 0, 0, 1, 0), 1'b0);
    req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(negedge sys_clk);
    rst_n = 1'b1;
    apply(mk(1, 8'h10, 1, 8'h20, 1, 0), 1'b1);
    repeat (6) apply(mk(0, 0, 0, 0, 0, 0), 1'b1);

    for (int k = 0; k < 20; k++) begin
      if (q1.size() == 0 && q2.size() == 0) break;
      @(negedge sys_clk);
    end
    chk("drain", q1.size() + q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares the single synchronous 256x8 ROM (`rom_256x8`) between two independent requesters, e.g. the key-driven address stepper and an auto-scan display sequencer. Each cycle it accepts at most one read, drives the ROM address and tracks which requester each in-flight read belongs to. It returns the ROM data with a per-requester valid strobe. It sits between the requesters and the ROM instance in the top level.

## Interface
- `RD_LAT`, default 1: sys_clk edges from `rom_addr` update to valid `rom_q`.
  - 1 = address-registered ROM.
  - 2 = ROM with output register.
  - Legal range 1..4.
- `sys_clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `req0` in 1: requester 0 read request, level.
- `addr0` in 8: requester 0 address, stable while `req0` high.
- `req1` in 1: requester 1 read request, level.
- `addr1` in 8: requester 1 address, stable while `req1` high.
- `gnt0` out 1: one-cycle pulse, requester 0 read issued.
- `gnt1` out 1: one-cycle pulse, requester 1 read issued.
- `rdata` out 8: returned ROM data, shared.
- `rvalid0` out 1: one-cycle pulse, `rdata` belongs to requester 0.
- `rvalid1` out 1: one-cycle pulse, `rdata` belongs to requester 1.
- `rom_addr` out 8: to ROM `address`.
- `rom_q` in 8: from ROM `q`.

## Operation
- Arbitration decision is made at each rising edge from `req0`/`req1` sampled at that edge.
  - The winner's `gnt` is asserted for the following cycle.
  - `rom_addr` is loaded with the winner's address at the same edge.
- Only one requester high: that requester wins, every cycle it stays high.
- Both high: the requester not granted most recently wins (round-robin). After reset, requester 0 counts as the "not most recent".
- Neither high: no `gnt`; `rom_addr` holds its last value; no tag is issued.
- Requester protocol:
  - Hold `req`/`addr` until `gnt` is seen.
  - Drop `req` during the `gnt` cycle if no further read is wanted.
  - `req` still high at the next edge is a new request (back-to-back reads are allowed).
- A tag pipe of depth `RD_LAT` carries {valid, id} per issued read.
  - At tag exit, `rom_q` is registered into `rdata` and the matching `rvalid` pulses.
- Returns are strictly in issue order; at most one `rvalid` is high per cycle.
- `rdata` holds its last value when no `rvalid` is high.
- There is no backpressure: requesters must accept data on `rvalid`.

## Timing
- Reset values:
  - `gnt0`, `gnt1`, `rvalid0`, `rvalid1` = 0.
  - `rdata` = 8'h00.
  - `rom_addr` = 8'h00.
  - Round-robin pointer = favour requester 0.
  - Tag pipe all invalid.
- `req` high in cycle C-1 gives `gnt` in cycle C, then `rvalid` + `rdata` in cycle C+`RD_LAT`+1.
- Throughput is one read per cycle in aggregate.
- When both requesters are continuously requesting, grants alternate 0,1,0,1...
- Reset asserted mid-operation:
  - All in-flight tags are discarded immediately.
  - No `rvalid` may appear for reads issued before reset.
- Deassertion of `rst_n` is released synchronously by the top level. The arbiter adds no extra reset latency: the first grant can occur at the first edge after release.

## Configuration
- `ROM_ARB_FIXED_PRIO_EN` defined: fixed priority.
  - `req0` always wins when both are high.
  - The round-robin pointer is not implemented.
  - Requester 1 may starve.
- Undefined (default): round-robin as described above.
- All other timing is identical in both builds.

## Structure
- Package `rom_arb_pkg`:
  - `ROM_AW` = 8, `ROM_DW` = 8.
  - `RD_LAT_MAX` = 4.
  - Requester id typedef (1 bit).
  - Tag struct {valid, id}.
- Sub-module `rom_arb_tag_pipe`: parameterised `RD_LAT`-deep shift register of tags, with async clear.
  - Instantiated once.
  - Outputs the exiting tag.

## Test plan
- Reset, no requests: all outputs 0 for 10 cycles; `rom_addr` = 8'h00.
- `req0` with `addr0`=8'h05 held one cycle, `RD_LAT`=1:
  - `gnt0` in the next cycle.
  - `rvalid0` two cycles after `gnt0`, with `rdata` = ROM[5].
  - `gnt1`/`rvalid1` never asserted.
- `req0`,`req1` both held 6 cycles, `addr0`=8'h10, `addr1`=8'h20:
  - Grants alternate 0,1,0,1,0,1.
  - `rvalid` sequence matches, with `rdata` alternating ROM[16]/ROM[32].
  - Repeat with `ROM_ARB_FIXED_PRIO_EN` defined: `gnt0` six times, `gnt1` zero.
- `RD_LAT`=2, `req1` continuous over addresses 8'hFE, 8'hFF, 8'h00:
  - Back-to-back `rvalid1` in order ROM[254], ROM[255], ROM[0].
  - Latency from `gnt` to `rvalid` is 3.
- `rst_n` pulsed low one cycle after `gnt0`: no `rvalid0` ever appears for that read; the post-reset grant goes to requester 0 when both request.
